// File: rtl/f_fetch_stage.sv
// f_fetch_stage: Y86-64 fetch stage with PC select, F register and byte-wide imem.
// Optional FETCH_PERF_EN adds saturating fetch/redirect counters.
module f_fetch_stage #(
  parameter int n = 64,
  parameter int IMEM_BYTES = 4096,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         F_stall,
  input  logic [3:0]   M_icode,
  input  logic         M_Cnd,
  input  logic [n-1:0] M_valA,
  input  logic [3:0]   W_icode,
  input  logic [n-1:0] W_valM,
  input  logic         imem_we,
  input  logic [n-1:0] imem_waddr,
  input  logic [7:0]   imem_wdata,
  output logic [3:0]   f_icode,
  output logic [3:0]   f_ifun,
  output logic [3:0]   f_rA,
  output logic [3:0]   f_rB,
  output logic [n-1:0] f_valC,
  output logic [n-1:0] f_valP,
  output logic [2:0]   f_stat,
  output logic [n-1:0] f_predPC,
  output logic [n-1:0] F_predPC
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_redirect
`endif
);
  localparam int AW = IMEM_BYTES > 1 ? $clog2(IMEM_BYTES) : 1;
  localparam logic [n:0] LIM = (n+1)'(IMEM_BYTES);
  logic [7:0] mem_q [IMEM_BYTES];
  logic [7:0] ib [10];
  logic [n-1:0] pred_pc_q, pred_pc_d, f_pc;
  logic [63:0] word;
  logic [3:0] icode, ifun, len;
  logic mispredict, ret_sel, need_regids, need_valc, ifun_ok, bad_instr, imem_error;

  assign mispredict = M_icode == 4'h7 && !M_Cnd;
  assign ret_sel = W_icode == 4'h9;
  assign f_pc = mispredict ? M_valA : ret_sel ? W_valM : pred_pc_q;

  // Addresses are widened by one bit so reads past the top never wrap into imem.
  for (genvar i = 0; i < 10; i++) begin : g_rd
    logic [n:0] a;
    assign a = {1'b0, f_pc} + (n+1)'(i);
    assign ib[i] = a < LIM ? mem_q[a[AW-1:0]] : 8'h00;
  end

  assign icode = ib[0][7:4];
  assign ifun = ib[0][3:0];
  assign need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  assign need_valc = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
  assign len = 4'd1 + {3'b0, need_regids} + {need_valc, 3'b0};
  assign imem_error = {1'b0, f_pc} + (n+1)'(len) - (n+1)'(1) >= LIM;
  assign ifun_ok = icode inside {4'h2, 4'h7} ? ifun <= 4'd6 : icode == 4'h6 ? ifun <= 4'd3 : ifun == 4'h0;
  assign bad_instr = icode > 4'hB || !ifun_ok;
  assign word = need_regids ? {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]}
                            : {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};

  assign f_icode = imem_error ? 4'h1 : icode;
  assign f_ifun = imem_error ? 4'h0 : ifun;
  assign f_rA = need_regids ? ib[1][7:4] : 4'hF;
  assign f_rB = need_regids ? ib[1][3:0] : 4'hF;
  assign f_valC = need_valc ? n'(word) : '0;
  assign f_valP = f_pc + n'(len);
  assign f_predPC = (icode == 4'h7 || icode == 4'h8) ? f_valC : f_valP;
  assign f_stat = imem_error ? 3'd3 : bad_instr ? 3'd4 : icode == 4'h0 ? 3'd2 : 3'd1;

  assign pred_pc_d = F_stall ? pred_pc_q : f_predPC;
  assign F_predPC = pred_pc_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pred_pc_q <= RESET_PC;
    else pred_pc_q <= pred_pc_d;

  always_ff @(posedge clk)
    if (imem_we && {1'b0, imem_waddr} < LIM) mem_q[imem_waddr[AW-1:0]] <= imem_wdata;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, redirect_q;
  assign perf_fetched = fetched_q;
  assign perf_redirect = redirect_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetched_q <= '0;
      redirect_q <= '0;
    end else if (!F_stall) begin
      if (f_stat == 3'd1 && ~&fetched_q) fetched_q <= fetched_q + 32'd1;
      if ((mispredict || ret_sel) && ~&redirect_q) redirect_q <= redirect_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_f_fetch_stage.sv
// tb_f_fetch_stage: vector table, hand-written sequences and random stimulus against
// a length-table reference model of the Y86-64 fetch stage.
module tb_f_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, F_stall, M_Cnd, imem_we;
  logic [3:0] M_icode, W_icode, f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] M_valA, W_valM, imem_waddr, f_valC, f_valP, f_predPC, F_predPC;
  logic [7:0] imem_wdata;
  logic [2:0] f_stat;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_redirect;
`endif

  f_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
    .f_predPC(f_predPC), .F_predPC(F_predPC)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_redirect(perf_redirect)
`endif
  );

  typedef struct {
    logic err;
    logic [3:0] icode, ifun, ra, rb;
    logic [63:0] valc, valp, pred;
    logic [2:0] stat;
  } exp_t;
  typedef struct {
    logic [63:0] addr;
    logic [79:0] bytes;
    int nb;
    exp_t e;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mm [4096];
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int imax_tab [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
  vec_t vt [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    imem_we = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
    if (a < 64'd4096) mm[a[11:0]] = d;
  endtask

  function automatic logic [7:0] mb(input logic [64:0] a);
    return a < 65'd4096 ? mm[a[11:0]] : 8'h00;
  endfunction

  // Regids exist exactly for the 2- and 10-byte forms, valC for the 9- and 10-byte forms.
  function automatic exp_t model(input logic [63:0] pc);
    exp_t e;
    logic [7:0] b0, b1;
    logic [3:0] ic, fn;
    int ln, off;
    b0 = mb({1'b0, pc});
    b1 = mb({1'b0, pc} + 65'd1);
    ic = b0[7:4];
    fn = b0[3:0];
    ln = len_tab[ic];
    e.err = ({1'b0, pc} + 65'(ln) - 65'd1) >= 65'd4096;
    off = (ln == 2 || ln == 10) ? 2 : 1;
    e.valc = '0;
    if (ln >= 9)
      for (int k = 0; k < 8; k++) e.valc |= 64'(mb({1'b0, pc} + 65'(off + k))) << (8 * k);
    e.ra = off == 2 ? b1[7:4] : 4'hF;
    e.rb = off == 2 ? b1[3:0] : 4'hF;
    e.valp = pc + 64'(ln);
    e.pred = (ic == 4'h7 || ic == 4'h8) ? e.valc : e.valp;
    e.stat = e.err ? 3'd3 : (int'(fn) > imax_tab[ic]) ? 3'd4 : ic == 4'h0 ? 3'd2 : 3'd1;
    e.icode = e.err ? 4'h1 : ic;
    e.ifun = e.err ? 4'h0 : fn;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".icode"}, 64'(f_icode), 64'(e.icode));
    chk({tag, ".ifun"}, 64'(f_ifun), 64'(e.ifun));
    chk({tag, ".stat"}, 64'(f_stat), 64'(e.stat));
    if (!e.err) begin
      chk({tag, ".rA"}, 64'(f_rA), 64'(e.ra));
      chk({tag, ".rB"}, 64'(f_rB), 64'(e.rb));
      chk({tag, ".valC"}, f_valC, e.valc);
      chk({tag, ".valP"}, f_valP, e.valp);
      chk({tag, ".predPC"}, f_predPC, e.pred);
    end
  endtask

  initial begin
    logic [63:0] fm, pc, wa;
    logic [7:0] wd;
    exp_t e;
    bit force_redir;
    vt[0]  = '{64'h100, 80'h30F20800000000000000, 10, '{1'b0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h8, 64'h10A, 64'h10A, 3'd1}};
    vt[1]  = '{64'h200, 80'h74200000000000000000, 9, '{1'b0, 4'h7, 4'h4, 4'hF, 4'hF, 64'h20, 64'h209, 64'h20, 3'd1}};
    vt[2]  = '{64'h300, 80'h80341200000000000000, 9, '{1'b0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'h309, 64'h1234, 3'd1}};
    vt[3]  = '{64'h310, 80'h90000000000000000000, 1, '{1'b0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h311, 64'h311, 3'd1}};
    vt[4]  = '{64'h320, 80'h00000000000000000000, 1, '{1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h321, 64'h321, 3'd2}};
    vt[5]  = '{64'h330, 80'h61230000000000000000, 2, '{1'b0, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h332, 64'h332, 3'd1}};
    vt[6]  = '{64'h340, 80'h64230000000000000000, 2, '{1'b0, 4'h6, 4'h4, 4'h2, 4'h3, 64'h0, 64'h342, 64'h342, 3'd4}};
    vt[7]  = '{64'h350, 80'hC0000000000000000000, 1, '{1'b0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h351, 64'h351, 3'd4}};
    vt[8]  = '{64'h360, 80'h25AB0000000000000000, 2, '{1'b0, 4'h2, 4'h5, 4'hA, 4'hB, 64'h0, 64'h362, 64'h362, 3'd1}};
    vt[9]  = '{64'h370, 80'h27AB0000000000000000, 2, '{1'b0, 4'h2, 4'h7, 4'hA, 4'hB, 64'h0, 64'h372, 64'h372, 3'd4}};
    vt[10] = '{64'h380, 80'h40158877665544332211, 10, '{1'b0, 4'h4, 4'h0, 4'h1, 4'h5, 64'h1122334455667788, 64'h38A, 64'h38A, 3'd1}};
    vt[11] = '{64'hFFB, 80'h30F20800000000000000, 5, '{1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 3'd3}};
    vt[12] = '{64'hFFF, 80'h10000000000000000000, 1, '{1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1000, 64'h1000, 3'd1}};
    vt[13] = '{64'hFFF, 80'hA0000000000000000000, 1, '{1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 3'd3}};
    vt[14] = '{64'hFF7, 80'h70400000000000000000, 9, '{1'b0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h1000, 64'h40, 3'd1}};
    vt[15] = '{64'hFFFFFFFFFFFFFFFF, 80'h0, 0, '{1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 3'd3}};
    rst_n = 1'b0; F_stall = 1'b1; M_icode = 4'h0; M_Cnd = 1'b0; M_valA = '0;
    W_icode = 4'h0; W_valM = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    for (int a = 0; a < 4096; a++) wr(64'(a), 8'h00);
    wr(64'h0, 8'h10);
    @(negedge clk);
    chk("reset.F_predPC", F_predPC, 64'h0);
    chk("reset.f_icode", 64'(f_icode), 64'h1);
    chk("reset.f_valP", f_valP, 64'h1);
    chk("reset.f_stat", 64'(f_stat), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1; F_stall = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("advance.F_predPC", F_predPC, 64'h1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset.F_predPC", F_predPC, 64'h0);
    F_stall = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr(64'h0, 8'h70);
    wr(64'h1, 8'h20);
    F_stall = 1'b0;
    @(negedge clk);
    chk("jmp.f_predPC", f_predPC, 64'h20);
    chk("jmp.f_icode", 64'(f_icode), 64'h7);
    @(posedge clk); #1;
    F_stall = 1'b1;
    @(negedge clk);
    chk("jmp.F_predPC", F_predPC, 64'h20);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h9;
    #1 chk("mispredict.f_valP", f_valP, 64'hA);
    chk("mispredict.f_stat", 64'(f_stat), 64'h2);
    M_Cnd = 1'b1;
    #1 chk("taken.f_valP", f_valP, 64'h21);
    @(posedge clk); #1;
    M_icode = 4'h0; W_icode = 4'h9; W_valM = 64'h40;
    @(negedge clk);
    chk("ret.f_valP", f_valP, 64'h41);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ret_stall.F_predPC", F_predPC, 64'h20);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h9;
    #1 chk("both.f_valP", f_valP, 64'hA);
    @(posedge clk); #1;
    F_stall = 1'b0;
    @(posedge clk); #1;
    F_stall = 1'b1;
    @(negedge clk);
    chk("both.F_predPC", F_predPC, 64'hA);
    @(posedge clk); #1;
    wr(64'd4096, 8'hFF);
    M_icode = 4'h0; W_icode = 4'h9; W_valM = 64'h0;
    @(negedge clk);
    chk("oob_write.f_icode", 64'(f_icode), 64'h7);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      M_icode = 4'h0; W_icode = 4'h9; W_valM = vt[i].addr;
      for (int k = 0; k < vt[i].nb; k++) wr(vt[i].addr + 64'(k), vt[i].bytes[79 - 8 * k -: 8]);
      @(negedge clk);
      compare($sformatf("vec%0d", i), vt[i].e);
      @(posedge clk); #1;
    end
`ifdef FETCH_PERF_EN
    for (int k = 0; k < 5; k++) wr(64'h500 + 64'(k), 8'h10);
    W_icode = 4'h0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    chk("perf.reset_fetched", 64'(perf_fetched), 64'h0);
    F_stall = 1'b0; W_icode = 4'h9; W_valM = 64'h500;
    @(posedge clk); #1;
    W_icode = 4'h0;
    repeat (4) @(posedge clk);
    #1 F_stall = 1'b1;
    @(negedge clk);
    chk("perf.fetched", 64'(perf_fetched), 64'h5);
    chk("perf.redirect", 64'(perf_redirect), 64'h1);
    chk("perf.F_predPC", F_predPC, 64'h505);
    @(posedge clk); #1;
`endif
    for (int a = 'h600; a < 'h700; a++) wr(64'(a), 8'($urandom));
    M_icode = 4'h0; W_icode = 4'h0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    fm = 64'h0;
    force_redir = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      M_icode = 4'($urandom); M_Cnd = 1'($urandom);
      M_valA = 64'h600 + 64'($urandom_range(0, 255));
      W_icode = 4'($urandom);
      W_valM = ($urandom_range(0, 7) == 0) ? 64'hFF0 + 64'($urandom_range(0, 15)) :
               ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'h600 + 64'($urandom_range(0, 255));
      if (force_redir) begin
        M_icode = 4'h7; M_Cnd = 1'b0; force_redir = 1'b0;
      end
      pc = (M_icode == 4'h7 && !M_Cnd) ? M_valA : (W_icode == 4'h9) ? W_valM : fm;
      e = model(pc);
      F_stall = e.err ? 1'b1 : ($urandom_range(0, 3) == 0);
      force_redir = e.err;
      wa = 64'h600 + 64'($urandom_range(0, 255));
      wd = 8'($urandom);
      imem_we = ($urandom_range(0, 7) == 0);
      imem_waddr = wa; imem_wdata = wd;
      @(negedge clk);
      compare("rnd", e);
      chk("rnd.F_predPC", F_predPC, fm);
      @(posedge clk); #1;
      if (!F_stall) fm = e.pred;
      if (imem_we) mm[wa[11:0]] = wd;
      imem_we = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
